// File: rtl/unified_memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction fetch port and
// the data port, with a single outstanding read and a grant lock while the bus stalls.
module unified_memory_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   inst_address,
   input  logic                    inst_read_enable,
   output logic                    inst_wait_req,
   output logic                    inst_valid,
   output logic [DATA_WIDTH-1:0]   inst_read_data,
   input  logic [ADDR_WIDTH-1:0]   data_address,
   input  logic                    data_read_enable,
   input  logic                    data_write_enable,
   input  logic [DATA_WIDTH/8-1:0] data_byte_enable,
   input  logic [DATA_WIDTH-1:0]   data_write_data,
   output logic                    data_wait_req,
   output logic                    data_valid,
   output logic [DATA_WIDTH-1:0]   data_read_data,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic                    mem_read_enable,
   output logic                    mem_write_enable,
   output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
   output logic [DATA_WIDTH-1:0]   mem_write_data,
   input  logic                    mem_wait_req,
   input  logic                    mem_valid,
   input  logic [DATA_WIDTH-1:0]   mem_read_data
);

   localparam int   BE_WIDTH   = DATA_WIDTH / 8;
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_INST = 2'd1,
      ST_WAIT_DATA = 2'd2
   } state_t;

   state_t r_state;
   logic   r_last_grant;
   logic   r_lock;
   logic   r_locked_owner;

   logic   w_inst_req;
   logic   w_data_req;
   logic   w_owner;
   logic   w_owner_req;
   logic   w_owner_read;
   logic   w_grant_active;
   logic   w_accept;

   assign w_inst_req = inst_read_enable;
   assign w_data_req = data_read_enable | data_write_enable;

   // Owner selection: a held lock wins, otherwise the side not granted last breaks a tie.
   always_comb begin
      if (r_lock) begin
         w_owner = r_locked_owner;
      end else if (w_inst_req && w_data_req) begin
         w_owner = ~r_last_grant;
      end else if (w_data_req) begin
         w_owner = OWNER_DATA;
      end else begin
         w_owner = OWNER_INST;
      end
   end

   assign w_owner_req    = (w_owner == OWNER_DATA) ? w_data_req : w_inst_req;
   assign w_owner_read   = (w_owner == OWNER_DATA) ? data_read_enable : inst_read_enable;
   assign w_grant_active = !reset && (r_state == ST_IDLE) && w_owner_req;
   assign w_accept       = w_grant_active && !mem_wait_req;

   // Read data is broadcast; only the matching valid qualifies it.
   assign inst_read_data = mem_read_data;
   assign data_read_data = mem_read_data;

   // Bus forwarding and response routing, all combinational with the memory.
   always_comb begin
      mem_address      = '0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_byte_enable  = '0;
      mem_write_data   = '0;
      inst_wait_req    = 1'b1;
      data_wait_req    = 1'b1;
      inst_valid       = 1'b0;
      data_valid       = 1'b0;
      if (reset) begin
         inst_valid = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_grant_active) begin
                  mem_read_enable = 1'b0;
               end else if (w_owner == OWNER_DATA) begin
                  mem_address      = data_address;
                  mem_read_enable  = data_read_enable;
                  // A simultaneous read wins; the write half is dropped.
                  mem_write_enable = data_write_enable & ~data_read_enable;
                  mem_byte_enable  = data_byte_enable;
                  mem_write_data   = data_write_data;
                  data_wait_req    = mem_wait_req;
               end else begin
                  mem_address     = inst_address;
                  mem_read_enable = 1'b1;
                  mem_byte_enable = {BE_WIDTH{1'b1}};
                  inst_wait_req   = mem_wait_req;
               end
            end
            ST_WAIT_INST: inst_valid = mem_valid;
            ST_WAIT_DATA: data_valid = mem_valid;
            default:      inst_valid = 1'b0;
         endcase
      end
   end

   // Arbitration FSM: grant, stall lock, round-robin history and read wait states.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_last_grant   <= OWNER_INST;
         r_lock         <= 1'b0;
         r_locked_owner <= OWNER_INST;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_lock       <= 1'b0;
                  r_last_grant <= w_owner;
                  if (w_owner_read) begin
                     r_state <= (w_owner == OWNER_DATA) ? ST_WAIT_DATA : ST_WAIT_INST;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_owner_req) begin
                  r_lock         <= 1'b1;
                  r_locked_owner <= w_owner;
               end else begin
                  // A withdrawn request must not leave the other side starved.
                  r_lock <= 1'b0;
               end
            end
            ST_WAIT_INST, ST_WAIT_DATA: begin
               if (mem_valid) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= r_state;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
